// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- IF-stage program counter and instruction-fetch sequencer.
//
// Owns the PC and its +4 increment. Runs a single-outstanding-request
// handshake with an instruction memory of any latency. Honours hazard
// stalls and EX-stage redirects, and hands (inst, if_pc, inst_valid) to IF/ID.
//
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   stall               hazard hold; IF/ID cannot take an instruction
//   redirect_valid      taken branch/jump from EX this cycle
//   redirect_target     new PC (bits [1:0] ignored)
//   imem_req/imem_addr  fetch request and word-aligned address
//   imem_ready          memory completes the outstanding request this cycle
//   imem_rdata          instruction word, valid with imem_ready
//   inst_valid/inst     instruction handed to IF/ID this cycle
//   if_pc               address of inst
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_BUF   = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] buf_inst, buf_inst_nx;
    logic [31:0] buf_pc, buf_pc_nx;
    logic [31:0] kill_addr, kill_addr_nx;
    logic        busy, busy_nx;

    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic        rdy;

    assign tgt    = {redirect_target[31:2], 2'b00};
    assign pc_inc = pc + 32'd4;
    // A ready with no request on the bus is not a completion.
    assign rdy    = imem_ready & imem_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            buf_inst  <= '0;
            buf_pc    <= RESET_PC;
            kill_addr <= RESET_PC;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            buf_inst  <= buf_inst_nx;
            buf_pc    <= buf_pc_nx;
            kill_addr <= kill_addr_nx;
            busy      <= busy_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        buf_inst_nx  = buf_inst;
        buf_pc_nx    = buf_pc;
        kill_addr_nx = kill_addr;
        busy_nx      = busy;
        imem_req     = 1'b0;
        imem_addr    = pc;
        inst_valid   = 1'b0;
        inst         = '0;
        if_pc        = pc;

        case (state)
            S_BOOT: begin
                state_nx = S_FETCH;
            end

            S_FETCH: begin
                // An outstanding request is never withdrawn, even under stall.
                imem_req = busy | ~stall;
                inst     = imem_rdata;
                if (rdy) begin
                    busy_nx = 1'b0;
                    if (redirect_valid) begin
                        pc_nx = tgt;
                    end else if (stall) begin
                        buf_inst_nx = imem_rdata;
                        buf_pc_nx   = pc;
                        pc_nx       = pc_inc;
                        state_nx    = S_BUF;
                    end else begin
                        inst_valid = 1'b1;
                        pc_nx      = pc_inc;
                    end
                end else if (redirect_valid) begin
                    pc_nx = tgt;
                    // The request on the bus still targets the old pc; its
                    // response must be swallowed in KILL.
                    if (imem_req) begin
                        kill_addr_nx = pc;
                        busy_nx      = 1'b1;
                        state_nx     = S_KILL;
                    end
                end else begin
                    busy_nx = imem_req;
                end
            end

            S_BUF: begin
                inst       = buf_inst;
                if_pc      = buf_pc;
                inst_valid = ~stall & ~redirect_valid;
                if (redirect_valid) begin
                    pc_nx    = tgt;
                    state_nx = S_FETCH;
                end else if (!stall) begin
                    state_nx = S_FETCH;
                end
            end

            S_KILL: begin
                imem_req  = 1'b1;
                imem_addr = kill_addr;
                if (redirect_valid)
                    pc_nx = tgt;
                if (imem_ready) begin
                    busy_nx  = 1'b0;
                    state_nx = S_FETCH;
                end else begin
                    busy_nx = 1'b1;
                end
            end

            default: begin
                state_nx = S_BOOT;
            end
        endcase
    end

endmodule
